// File: rtl/ext_pkg.sv
// Mode codes shared by the extension unit and its decoder/control neighbours.
package ext_pkg;

    localparam int unsigned EXT_MODE_W = 3;

    typedef enum logic [EXT_MODE_W-1:0] {
        EXT_SIGN = 3'd0,
        EXT_ZERO = 3'd1,
        EXT_LUI  = 3'd2,
        EXT_LB   = 3'd3,
        EXT_LBU  = 3'd4,
        EXT_LH   = 3'd5,
        EXT_LHU  = 3'd6,
        EXT_WORD = 3'd7
    } ext_mode_e;

endpackage

// File: rtl/ext_core.sv
// Combinational extender: immediate and load-lane extension plus alignment fault.
module ext_core
    import ext_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IMM_W  = 16,
    parameter int unsigned OFS_W  = 2
) (
    input  ext_mode_e         mode,
    input  logic [IMM_W-1:0]  imm,
    input  logic [DATA_W-1:0] data,
    input  logic [OFS_W-1:0]  ofs,
    output logic [DATA_W-1:0] result_c,
    output logic              misalign_c
);

    logic [OFS_W-1:0] half_ofs;
    logic [7:0]       byte_lane;
    logic [15:0]      half_lane;

    // Lane extraction: byte at ofs, halfword at the even byte below ofs.
    always_comb begin
        half_ofs  = ofs & ~OFS_W'(1);
        byte_lane = 8'(data >> {ofs, 3'b000});
        half_lane = 16'(data >> {half_ofs, 3'b000});
    end

    // Mode decode; a faulting access returns zero so nothing stale leaks downstream.
    always_comb begin
        result_c   = '0;
        misalign_c = 1'b0;
        unique case (mode)
            EXT_SIGN: result_c = DATA_W'($signed(imm));
            EXT_ZERO: result_c = DATA_W'(imm);
            EXT_LUI:  result_c = DATA_W'(imm) << (DATA_W - IMM_W);
            EXT_LB:   result_c = DATA_W'($signed(byte_lane));
            EXT_LBU:  result_c = DATA_W'(byte_lane);
            EXT_LH: begin
                if (ofs[0]) misalign_c = 1'b1;
                else        result_c   = DATA_W'($signed(half_lane));
            end
            EXT_LHU: begin
                if (ofs[0]) misalign_c = 1'b1;
                else        result_c   = DATA_W'(half_lane);
            end
            EXT_WORD: begin
                if (ofs != '0) misalign_c = 1'b1;
                else           result_c   = data;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ext_unit.sv
// Registered immediate/load extender with valid/ready handshake and a skid entry.
module ext_unit
    import ext_pkg::*;
#(
    parameter  int unsigned DATA_W = 32,
    parameter  int unsigned IMM_W  = 16,
    parameter  int unsigned TAG_W  = 5,
    localparam int unsigned OFS_W  = $clog2(DATA_W / 8)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [EXT_MODE_W-1:0] in_mode,
    input  logic [IMM_W-1:0]      in_imm,
    input  logic [DATA_W-1:0]     in_data,
    input  logic [OFS_W-1:0]      in_ofs,
    input  logic [TAG_W-1:0]      in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_result,
    output logic                  out_misalign,
    output logic [TAG_W-1:0]      out_tag
);

    logic [DATA_W-1:0] core_result;
    logic              core_misalign;

    logic              skid_valid;
    logic [DATA_W-1:0] skid_result;
    logic              skid_misalign;
    logic [TAG_W-1:0]  skid_tag;

    logic in_xfer;
    logic out_load;

    ext_core #(
        .DATA_W (DATA_W),
        .IMM_W  (IMM_W),
        .OFS_W  (OFS_W)
    ) u_core (
        .mode       (ext_mode_e'(in_mode)),
        .imm        (in_imm),
        .data       (in_data),
        .ofs        (in_ofs),
        .result_c   (core_result),
        .misalign_c (core_misalign)
    );

    // in_ready comes straight from the skid flop, so out_ready never reaches it.
    assign in_ready = ~skid_valid;
    assign in_xfer  = in_valid & in_ready;
    assign out_load = ~out_valid | out_ready;

    // Output register fed from skid first (ordering), skid catches inputs during a stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid     <= 1'b0;
            out_result    <= '0;
            out_misalign  <= 1'b0;
            out_tag       <= '0;
            skid_valid    <= 1'b0;
            skid_result   <= '0;
            skid_misalign <= 1'b0;
            skid_tag      <= '0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (out_load) begin
            if (skid_valid) begin
                out_valid    <= 1'b1;
                out_result   <= skid_result;
                out_misalign <= skid_misalign;
                out_tag      <= skid_tag;
                skid_valid   <= 1'b0;
            end else begin
                out_valid <= in_xfer;
                if (in_xfer) begin
                    out_result   <= core_result;
                    out_misalign <= core_misalign;
                    out_tag      <= in_tag;
                end
            end
        end else if (in_xfer) begin
            skid_valid    <= 1'b1;
            skid_result   <= core_result;
            skid_misalign <= core_misalign;
            skid_tag      <= in_tag;
        end
    end

endmodule

// File: tb/tb_ext_unit.sv
// Bench for ext_unit: directed cases plus randomized traffic against a reference model.
module tb_ext_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_mode;
    logic [15:0] in_imm;
    logic [31:0] in_data;
    logic [1:0]  in_ofs;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_misalign;
    logic [4:0]  out_tag;

    typedef struct packed {
        logic [31:0] result;
        logic        misalign;
        logic [4:0]  tag;
    } exp_t;

    exp_t       sb[$];
    logic [4:0] got_tags[$];
    int         got_cyc[$];
    logic       rec = 1'b0;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;

    ext_unit dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_mode      (in_mode),
        .in_imm       (in_imm),
        .in_data      (in_data),
        .in_ofs       (in_ofs),
        .in_tag       (in_tag),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_misalign (out_misalign),
        .out_tag      (out_tag)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: arithmetic on byte/halfword values, not on bit slices of the RTL.
    function automatic exp_t model(input int mode, input logic [15:0] imm, input logic [31:0] data,
                                   input int ofs, input logic [4:0] tag);
        int unsigned b;
        int unsigned h;
        exp_t e;
        b = (data >> (8 * ofs)) & 32'hFF;
        h = (data >> (16 * (ofs / 2))) & 32'hFFFF;
        e.result   = '0;
        e.misalign = 1'b0;
        e.tag      = tag;
        case (mode)
            0: e.result = imm[15] ? 32'(imm) + 32'hFFFF0000 : 32'(imm);
            1: e.result = 32'(imm);
            2: e.result = 32'(imm) * 32'd65536;
            3: e.result = (b >= 128) ? b - 256 : b;
            4: e.result = b;
            5, 6: begin
                if (ofs % 2 != 0) e.misalign = 1'b1;
                else e.result = (mode == 5 && h >= 32768) ? h - 65536 : h;
            end
            default: begin
                if (ofs != 0) e.misalign = 1'b1;
                else e.result = data;
            end
        endcase
        return e;
    endfunction

    // Monitor/scoreboard: pop on every output transfer, then record the input side.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_out", 32'(out_tag), 32'hFFFFFFFF);
            end else begin
                e = sb.pop_front();
                check("sb_result", out_result, e.result);
                check("sb_misalign", 32'(out_misalign), 32'(e.misalign));
                check("sb_tag", 32'(out_tag), 32'(e.tag));
            end
            if (rec) begin
                got_tags.push_back(out_tag);
                got_cyc.push_back(cyc);
            end
        end
        if (reset || flush) sb.delete();
        else if (in_valid && in_ready)
            sb.push_back(model(int'(in_mode), in_imm, in_data, int'(in_ofs), in_tag));
    end

    task automatic drive(input logic [2:0] m, input logic [15:0] imm, input logic [31:0] d,
                         input logic [1:0] o, input logic [4:0] t);
        in_valid = 1'b1;
        in_mode  = m;
        in_imm   = imm;
        in_data  = d;
        in_ofs   = o;
        in_tag   = t;
    endtask

    // Wait (bounded) for the handshake, return just after the accepting edge.
    task automatic wait_accept();
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic send_check(input string name, input logic [2:0] m, input logic [15:0] imm,
                              input logic [31:0] d, input logic [1:0] o,
                              input logic [31:0] exp_r, input logic exp_m);
        drive(m, imm, d, o, 5'd0);
        wait_accept();
        @(negedge clk);
        check({name, "_valid"}, 32'(out_valid), 32'd1);
        check({name, "_result"}, out_result, exp_r);
        check({name, "_misalign"}, 32'(out_misalign), 32'(exp_m));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic done;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_mode = '0; in_imm = '0; in_data = '0; in_ofs = '0; in_tag = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_result", out_result, 32'd0);
        check("rst_tag", 32'(out_tag), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        out_ready = 1'b1;

        // Immediate and load-lane cases
        send_check("sign",     3'd0, 16'h8001, 32'd0, 2'd0, 32'hFFFF8001, 1'b0);
        send_check("zero",     3'd1, 16'h8001, 32'd0, 2'd0, 32'h00008001, 1'b0);
        send_check("lui",      3'd2, 16'h8001, 32'd0, 2'd3, 32'h80010000, 1'b0);
        send_check("lb2",      3'd3, 16'd0, 32'h12F45678, 2'd2, 32'hFFFFFFF4, 1'b0);
        send_check("lbu2",     3'd4, 16'd0, 32'h12F45678, 2'd2, 32'h000000F4, 1'b0);
        send_check("lb3",      3'd3, 16'd0, 32'h12F45678, 2'd3, 32'h00000012, 1'b0);
        send_check("lh2",      3'd5, 16'd0, 32'h12F45678, 2'd2, 32'h000012F4, 1'b0);
        send_check("lh0",      3'd5, 16'd0, 32'h12F4D678, 2'd0, 32'hFFFFD678, 1'b0);
        send_check("lhu1",     3'd6, 16'd0, 32'h12F45678, 2'd1, 32'h00000000, 1'b1);
        send_check("word3",    3'd7, 16'd0, 32'h12F45678, 2'd3, 32'h00000000, 1'b1);
        send_check("word0",    3'd7, 16'd0, 32'h12F45678, 2'd0, 32'h12F45678, 1'b0);

        // Stall: tag1 in output, tag2 in skid, tag3 held by source
        out_ready = 1'b0;
        got_tags.delete();
        got_cyc.delete();
        rec = 1'b1;
        drive(3'd0, 16'h0001, 32'd0, 2'd0, 5'd1); wait_accept();
        drive(3'd0, 16'h0002, 32'd0, 2'd0, 5'd2); wait_accept();
        drive(3'd0, 16'h0003, 32'd0, 2'd0, 5'd3);
        repeat (3) begin
            @(negedge clk);
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_tag", 32'(out_tag), 32'd1);
            check("stall_result", out_result, 32'd1);
            check("stall_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_accept();
        repeat (3) @(negedge clk);
        rec = 1'b0;
        check("order_count", 32'(got_tags.size()), 32'd3);
        if (got_tags.size() == 3) begin
            check("order_0", 32'(got_tags[0]), 32'd1);
            check("order_1", 32'(got_tags[1]), 32'd2);
            check("order_2", 32'(got_tags[2]), 32'd3);
            check("order_gap", 32'(got_cyc[2] - got_cyc[0]), 32'd2);
        end
        @(posedge clk);
        #1;

        // Flush with output and skid full, input pending
        out_ready = 1'b0;
        drive(3'd1, 16'h0004, 32'd0, 2'd0, 5'd4); wait_accept();
        drive(3'd1, 16'h0005, 32'd0, 2'd0, 5'd5); wait_accept();
        drive(3'd1, 16'h0006, 32'd0, 2'd0, 5'd6);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        // Input handshaking in the flush cycle is discarded
        drive(3'd1, 16'h0007, 32'd0, 2'd0, 5'd7);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("flush_discard", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;

        // Reset during a stall
        out_ready = 1'b0;
        drive(3'd0, 16'h1234, 32'd0, 2'd0, 5'd8); wait_accept();
        drive(3'd0, 16'h4321, 32'd0, 2'd0, 5'd9); wait_accept();
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst2_out_valid", 32'(out_valid), 32'd0);
        check("rst2_result", out_result, 32'd0);
        check("rst2_tag", 32'(out_tag), 32'd0);
        check("rst2_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 out_ready = 1'b1;
        send_check("post_rst", 3'd0, 16'h7FFF, 32'd0, 2'd0, 32'h00007FFF, 1'b0);

        // Randomized traffic with random backpressure and occasional flush
        for (int i = 0; i < 600; i++) begin
            if (!in_valid && $urandom_range(0, 3) != 0)
                drive(3'($urandom_range(0, 7)), 16'($urandom), 32'($urandom),
                      2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)));
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 40) == 0);
            @(negedge clk);
            done = (in_valid && in_ready) || flush;
            @(posedge clk);
            #1 flush = 1'b0;
            if (done) in_valid = 1'b0;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("drain_empty", 32'(sb.size()), 32'd0);
        check("drain_idle", 32'(out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
